// File: rtl/tone_sequencer.sv
// tone_sequencer
//
// Plays a short multi-note cue on a square-wave output for each vend or
// error event. Vend cues rise in pitch (base, 1.25x, 1.5x, 1.75x). Error
// cues repeat a single low note. Events are buffered in a small FIFO, so
// back-to-back requests queue up instead of cutting each other off.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   vend_event   one-cycle pulse, vend completed (item in item_select)
//   error_event  one-cycle pulse, error cue request
//   item_select  item number for vend_event, sampled in the same cycle
//   audio_out    square-wave audio, low whenever no note is sounding
//   busy         FIFO non-empty or a cue in progress
//   queue_full   FIFO holds QUEUE_DEPTH entries
//   dropped      one-cycle pulse, an event was discarded
//
// Optional feature (macro ERROR_PREEMPT_EN):
//   When defined, error_event flushes the FIFO, aborts any cue in progress
//   and starts an error cue on the next edge. When undefined, an error is
//   queued like any other cue.

module tone_sequencer #(
    parameter int CLOCK_HZ      = 100_000_000,
    parameter int ITEM0_FREQ_HZ = 800,
    parameter int ITEM1_FREQ_HZ = 1000,
    parameter int ITEM2_FREQ_HZ = 1200,
    parameter int ITEM3_FREQ_HZ = 1400,
    parameter int ERROR_FREQ_HZ = 300,
    parameter int NOTES_PER_CUE = 3,
    parameter int NOTE_MS       = 100,
    parameter int GAP_MS        = 20,
    parameter int QUEUE_DEPTH   = 4,
    parameter int DIV_W         = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vend_event,
    input  logic       error_event,
    input  logic [1:0] item_select,
    output logic       audio_out,
    output logic       busy,
    output logic       queue_full,
    output logic       dropped
);

    localparam int CYC_PER_MS = CLOCK_HZ / 1000;
    localparam int NOTE_CYC   = CYC_PER_MS * NOTE_MS;
    localparam int GAP_CYC    = CYC_PER_MS * GAP_MS;
    localparam int MAX_CYC    = (NOTE_CYC > GAP_CYC) ? NOTE_CYC : GAP_CYC;
    localparam int TMR_W      = $clog2(MAX_CYC + 1);
    localparam int PTR_W      = $clog2(QUEUE_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam bit HAS_GAP    = (GAP_CYC != 0);

    // Half-period in clock cycles for cue code (0..3 vend, 4 error) and note n.
    // Vend notes are base*(4+n)/4, folded into one integer division so the
    // fractional frequency never has to be represented.
    function automatic longint calc_half(input int code, input int n);
        longint base;
        longint result;
        case (code)
            0:       base = longint'(ITEM0_FREQ_HZ);
            1:       base = longint'(ITEM1_FREQ_HZ);
            2:       base = longint'(ITEM2_FREQ_HZ);
            3:       base = longint'(ITEM3_FREQ_HZ);
            default: base = longint'(ERROR_FREQ_HZ);
        endcase
        if (code >= 4)
            result = longint'(CLOCK_HZ) / (longint'(2) * base);
        else
            result = (longint'(2) * longint'(CLOCK_HZ)) / (base * longint'(4 + n));
        return result;
    endfunction

    // Table is 32 entries wide so any {code, note_idx} index stays in range;
    // entries 20..31 are never selected.
    function automatic logic [32*DIV_W-1:0] build_table();
        logic [32*DIV_W-1:0] t;
        t = '0;
        for (int c = 0; c < 5; c++)
            for (int n = 0; n < 4; n++)
                t[(c*4+n)*DIV_W +: DIV_W] = DIV_W'(calc_half(c, n));
        return t;
    endfunction

    function automatic bit halves_ok();
        bit     ok;
        longint h;
        ok = 1'b1;
        for (int c = 0; c < 5; c++)
            for (int n = 0; n < 4; n++) begin
                h = calc_half(c, n);
                if (h == 0 || h >= (longint'(1) << DIV_W))
                    ok = 1'b0;
            end
        return ok;
    endfunction

    localparam logic [32*DIV_W-1:0] HALF_TABLE = build_table();

    generate
        if (!halves_ok()) begin : g_bad_half
            $error("tone_sequencer: a half-period is zero or does not fit in DIV_W bits");
        end
        if (NOTES_PER_CUE < 1 || NOTES_PER_CUE > 4) begin : g_bad_notes
            $error("tone_sequencer: NOTES_PER_CUE must be 1..4");
        end
        if (QUEUE_DEPTH < 2 || QUEUE_DEPTH > 16 || (1 << PTR_W) != QUEUE_DEPTH) begin : g_bad_depth
            $error("tone_sequencer: QUEUE_DEPTH must be a power of two in 2..16");
        end
        if (NOTE_CYC < 1) begin : g_bad_note_len
            $error("tone_sequencer: NOTE_MS must give at least one cycle");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        NOTE,
        GAP
    } state_t;

    state_t state;
    state_t next_state;

    logic [2:0]       fifo_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_empty;
    logic             fifo_full;
    logic [2:0]       head_code;

    logic             preempt;
    logic             wr_req;
    logic             wr_en;
    logic [2:0]       wr_code;
    logic             drop_now;

    logic             pop;
    logic             start_cue;
    logic [2:0]       start_code;
    logic             next_note;
    logic             start_gap;

    logic [2:0]       cue_code;
    logic [1:0]       note_idx;
    logic [TMR_W-1:0] timer;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] half;
    logic [4:0]       half_idx;
    logic             sq;
    logic             timer_done;
    logic             last_note;

`ifdef ERROR_PREEMPT_EN
    assign preempt = error_event;
`else
    assign preempt = 1'b0;
`endif

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(QUEUE_DEPTH));
    assign head_code  = fifo_mem[rd_ptr];
    assign timer_done = (timer == TMR_W'(1));
    assign last_note  = (note_idx == 2'(NOTES_PER_CUE - 1));
    assign half_idx   = {cue_code, note_idx};
    assign half       = HALF_TABLE[half_idx * DIV_W +: DIV_W];

    // Error wins over a simultaneous vend; a preempting error bypasses the
    // FIFO entirely. A full FIFO still accepts a write when the head is
    // being popped in the same cycle.
    always_comb begin
        wr_code  = error_event ? 3'd4 : {1'b0, item_select};
        wr_req   = (vend_event | error_event) & ~preempt;
        wr_en    = wr_req & (~fifo_full | pop);
        drop_now = (vend_event & error_event) | (wr_req & ~wr_en);
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            fifo_mem[wr_ptr] <= wr_code;
    end

    always_ff @(posedge clk) begin
        if (rst || preempt) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            dropped <= 1'b0;
        else
            dropped <= drop_now;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // FSM next-state logic. With no gap configured, a finished note goes
    // straight to the next note (or IDLE) without visiting GAP.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        start_cue  = 1'b0;
        start_code = head_code;
        next_note  = 1'b0;
        start_gap  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    start_cue  = 1'b1;
                    next_state = NOTE;
                end
            end
            NOTE: begin
                if (timer_done) begin
                    if (HAS_GAP) begin
                        start_gap  = 1'b1;
                        next_state = GAP;
                    end else if (!last_note) begin
                        next_note  = 1'b1;
                        next_state = NOTE;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            GAP: begin
                if (timer_done) begin
                    if (!last_note) begin
                        next_note  = 1'b1;
                        next_state = NOTE;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
        if (preempt) begin
            pop        = 1'b0;
            start_cue  = 1'b1;
            start_code = 3'd4;
            next_note  = 1'b0;
            start_gap  = 1'b0;
            next_state = NOTE;
        end
    end

    // Note timer, divider and square-wave phase. Every note starts with the
    // phase low and the divider cleared, so the first rise lands exactly
    // HALF cycles after the note begins.
    always_ff @(posedge clk) begin
        if (rst) begin
            cue_code <= '0;
            note_idx <= '0;
            timer    <= '0;
            div_cnt  <= '0;
            sq       <= 1'b0;
        end else if (start_cue) begin
            cue_code <= start_code;
            note_idx <= '0;
            timer    <= TMR_W'(NOTE_CYC);
            div_cnt  <= '0;
            sq       <= 1'b0;
        end else if (next_note) begin
            note_idx <= note_idx + 2'd1;
            timer    <= TMR_W'(NOTE_CYC);
            div_cnt  <= '0;
            sq       <= 1'b0;
        end else if (start_gap) begin
            timer    <= TMR_W'(GAP_CYC);
            div_cnt  <= '0;
            sq       <= 1'b0;
        end else if (state == NOTE) begin
            timer <= timer - TMR_W'(1);
            if (div_cnt == half - DIV_W'(1)) begin
                div_cnt <= '0;
                sq      <= ~sq;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end else if (state == GAP) begin
            timer <= timer - TMR_W'(1);
        end
    end

    // FSM outputs. Gating with the state guarantees silence in IDLE and GAP.
    always_comb begin
        audio_out  = (state == NOTE) & sq;
        busy       = ~fifo_empty | (state != IDLE);
        queue_full = fifo_full;
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer
//
// Directed bench for tone_sequencer at CLOCK_HZ=1 MHz, 1 ms notes and gaps,
// three notes per cue and a four-entry queue. A table of timed checkpoints
// covers single cues, errors and queue overflow; hand-written sequences
// cover the no-gap build, reset mid-note and (when ERROR_PREEMPT_EN is
// defined) error preemption. Edge numbers below are counted from the edge
// that samples the first event pulse of each group (edge 0).

module tb_tone_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       vend_event;
    logic       error_event;
    logic [1:0] item_select;
    logic       audio_out;
    logic       busy;
    logic       queue_full;
    logic       dropped;

    logic       vend_ng;
    logic       error_ng;
    logic [1:0] item_ng;
    logic       audio_ng;
    logic       busy_ng;
    logic       full_ng;
    logic       dropped_ng;

    int checks = 0;
    int errors = 0;
    int cur    = -1;

`ifdef ERROR_PREEMPT_EN
    localparam int ERR_LAT = 0;
`else
    localparam int ERR_LAT = 1;
`endif

    always #5 clk = ~clk;

    tone_sequencer #(
        .CLOCK_HZ      (1_000_000),
        .NOTE_MS       (1),
        .GAP_MS        (1),
        .NOTES_PER_CUE (3),
        .QUEUE_DEPTH   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .vend_event  (vend_event),
        .error_event (error_event),
        .item_select (item_select),
        .audio_out   (audio_out),
        .busy        (busy),
        .queue_full  (queue_full),
        .dropped     (dropped)
    );

    tone_sequencer #(
        .CLOCK_HZ      (1_000_000),
        .NOTE_MS       (1),
        .GAP_MS        (0),
        .NOTES_PER_CUE (3),
        .QUEUE_DEPTH   (4)
    ) dut_nogap (
        .clk         (clk),
        .rst         (rst),
        .vend_event  (vend_ng),
        .error_event (error_ng),
        .item_select (item_ng),
        .audio_out   (audio_ng),
        .busy        (busy_ng),
        .queue_full  (full_ng),
        .dropped     (dropped_ng)
    );

    typedef struct {
        string      name;
        bit         first;
        bit         vend;
        bit         err;
        logic [1:0] item;
        int         at;
        logic       exp_audio;
        logic       exp_busy;
        logic       exp_full;
        logic       exp_drop;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string name, input bit first, input bit vend,
                           input bit err, input logic [1:0] item, input int at,
                           input logic a, input logic b, input logic f, input logic d);
        vec_t v;
        v.name = name; v.first = first; v.vend = vend; v.err = err; v.item = item;
        v.at = at; v.exp_audio = a; v.exp_busy = b; v.exp_full = f; v.exp_drop = d;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Advance to edge 'target', sampling #1 after each edge. Pulses are
    // cleared after the edge that samples them, and item_select is
    // scrambled so a cue can only depend on the value captured at enqueue.
    task automatic tick_to(input int target);
        while (cur < target) begin
            @(posedge clk);
            #1;
            vend_event  = 1'b0;
            error_event = 1'b0;
            vend_ng     = 1'b0;
            item_select = 2'($urandom_range(0, 3));
            item_ng     = 2'($urandom_range(0, 3));
            cur++;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.first)
            cur = -1;
        vend_event  = v.vend;
        error_event = v.err;
        if (v.vend)
            item_select = v.item;
        if (v.at <= cur) begin
            errors++;
            $display("[TB] FAIL %s: table time %0d not after %0d", v.name, v.at, cur);
        end
        tick_to(v.at);
    endtask

    // Count cycles up to 'target' in which audio_out or dropped is high.
    task automatic monitor_to(input int target, output int bad);
        bad = 0;
        while (cur < target) begin
            tick_to(cur + 1);
            if (audio_out !== 1'b0 || dropped !== 1'b0)
                bad++;
        end
    endtask

    initial begin
        int bad;

        rst         = 1'b1;
        vend_event  = 1'b0;
        error_event = 1'b0;
        item_select = 2'd0;
        vend_ng     = 1'b0;
        error_ng    = 1'b0;
        item_ng     = 2'd0;

        // Single vend, item 0: halves 625 / 500 / 416, cue enters NOTE at edge 1.
        add_vec("single_enq",   1, 1, 0, 2'd0,    0, 0, 1, 0, 0);
        add_vec("single_pre",   0, 0, 0, 2'd0,  625, 0, 1, 0, 0);
        add_vec("single_rise",  0, 0, 0, 2'd0,  626, 1, 1, 0, 0);
        add_vec("single_n0end", 0, 0, 0, 2'd0, 1000, 1, 1, 0, 0);
        add_vec("single_gap0",  0, 0, 0, 2'd0, 1001, 0, 1, 0, 0);
        add_vec("single_n1pre", 0, 0, 0, 2'd0, 2500, 0, 1, 0, 0);
        add_vec("single_n1up",  0, 0, 0, 2'd0, 2501, 1, 1, 0, 0);
        add_vec("single_n2pre", 0, 0, 0, 2'd0, 4416, 0, 1, 0, 0);
        add_vec("single_n2up",  0, 0, 0, 2'd0, 4417, 1, 1, 0, 0);
        add_vec("single_n2hi",  0, 0, 0, 2'd0, 4832, 1, 1, 0, 0);
        add_vec("single_n2dn",  0, 0, 0, 2'd0, 4833, 0, 1, 0, 0);
        add_vec("single_busy",  0, 0, 0, 2'd0, 6000, 0, 1, 0, 0);
        add_vec("single_done",  0, 0, 0, 2'd0, 6001, 0, 0, 0, 0);

        // Error cue: half 1666 exceeds the 1000-cycle note, so it stays silent.
        add_vec("err_enq",      1, 0, 1, 2'd0,    0,              0, 1, 0, 0);
        add_vec("err_mid",      0, 0, 0, 2'd0, 1000,              0, 1, 0, 0);
        add_vec("err_busy",     0, 0, 0, 2'd0, 5999 + ERR_LAT,    0, 1, 0, 0);
        add_vec("err_done",     0, 0, 0, 2'd0, 6000 + ERR_LAT,    0, 0, 0, 0);

        // Vend + error together: error cue plays, vend dropped.
        add_vec("ve_drop",      1, 1, 1, 2'd2,    0,              0, 1, 0, 1);
        add_vec("ve_dropclr",   0, 0, 0, 2'd0,    1,              0, 1, 0, 0);
        add_vec("ve_noitem",    0, 0, 0, 2'd0,  500,              0, 1, 0, 0);
        add_vec("ve_busy",      0, 0, 0, 2'd0, 5999 + ERR_LAT,    0, 1, 0, 0);
        add_vec("ve_done",      0, 0, 0, 2'd0, 6000 + ERR_LAT,    0, 0, 0, 0);

        // Overflow: items 0,1,2,3,0,1 on consecutive edges. Cue j starts at
        // edge 1+6001*j; first halves 625, 500, 416, 357, 625.
        add_vec("ovf_p0",       1, 1, 0, 2'd0,     0, 0, 1, 0, 0);
        add_vec("ovf_p1",       0, 1, 0, 2'd1,     1, 0, 1, 0, 0);
        add_vec("ovf_p2",       0, 1, 0, 2'd2,     2, 0, 1, 0, 0);
        add_vec("ovf_p3",       0, 1, 0, 2'd3,     3, 0, 1, 0, 0);
        add_vec("ovf_p4",       0, 1, 0, 2'd0,     4, 0, 1, 1, 0);
        add_vec("ovf_p5",       0, 1, 0, 2'd1,     5, 0, 1, 1, 1);
        add_vec("ovf_after",    0, 0, 0, 2'd0,     6, 0, 1, 1, 0);
        add_vec("ovf_c0pre",    0, 0, 0, 2'd0,   625, 0, 1, 1, 0);
        add_vec("ovf_c0up",     0, 0, 0, 2'd0,   626, 1, 1, 1, 0);
        add_vec("ovf_c0end",    0, 0, 0, 2'd0,  6001, 0, 1, 1, 0);
        add_vec("ovf_c1pop",    0, 0, 0, 2'd0,  6002, 0, 1, 0, 0);
        add_vec("ovf_c1pre",    0, 0, 0, 2'd0,  6501, 0, 1, 0, 0);
        add_vec("ovf_c1up",     0, 0, 0, 2'd0,  6502, 1, 1, 0, 0);
        add_vec("ovf_c2pre",    0, 0, 0, 2'd0, 12418, 0, 1, 0, 0);
        add_vec("ovf_c2up",     0, 0, 0, 2'd0, 12419, 1, 1, 0, 0);
        add_vec("ovf_c3pre",    0, 0, 0, 2'd0, 18360, 0, 1, 0, 0);
        add_vec("ovf_c3up",     0, 0, 0, 2'd0, 18361, 1, 1, 0, 0);
        add_vec("ovf_c4pre",    0, 0, 0, 2'd0, 24629, 0, 1, 0, 0);
        add_vec("ovf_c4up",     0, 0, 0, 2'd0, 24630, 1, 1, 0, 0);
        add_vec("ovf_busy",     0, 0, 0, 2'd0, 30004, 0, 1, 0, 0);
        add_vec("ovf_done",     0, 0, 0, 2'd0, 30005, 0, 0, 0, 0);
        add_vec("ovf_no6th",    0, 0, 0, 2'd0, 30700, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        $display("[TB] reset released");
        checkOutput("reset audio", audio_out, 1'b0);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset full", queue_full, 1'b0);
        checkOutput("reset dropped", dropped, 1'b0);
        checkOutput("reset nogap busy", busy_ng, 1'b0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("%s audio", vecs[i].name), audio_out, vecs[i].exp_audio);
            checkOutput($sformatf("%s busy", vecs[i].name), busy, vecs[i].exp_busy);
            checkOutput($sformatf("%s full", vecs[i].name), queue_full, vecs[i].exp_full);
            checkOutput($sformatf("%s dropped", vecs[i].name), dropped, vecs[i].exp_drop);
        end

        // No-gap build: notes abut; each new note restarts low and its first
        // rise comes exactly one half-period after the boundary edge.
        $display("[TB] no-gap sequence");
        cur     = -1;
        vend_ng = 1'b1;
        item_ng = 2'd0;
        tick_to(0);
        checkOutput("nogap enq busy", busy_ng, 1'b1);
        tick_to(1000);
        checkOutput("nogap n0 end", audio_ng, 1'b1);
        tick_to(1001);
        checkOutput("nogap boundary", audio_ng, 1'b0);
        tick_to(1500);
        checkOutput("nogap n1 pre", audio_ng, 1'b0);
        tick_to(1501);
        checkOutput("nogap n1 rise", audio_ng, 1'b1);
        tick_to(2000);
        checkOutput("nogap n1 end", audio_ng, 1'b1);
        tick_to(2416);
        checkOutput("nogap n2 pre", audio_ng, 1'b0);
        tick_to(2417);
        checkOutput("nogap n2 rise", audio_ng, 1'b1);
        tick_to(3000);
        checkOutput("nogap busy", busy_ng, 1'b1);
        tick_to(3001);
        checkOutput("nogap done", busy_ng, 1'b0);

        // Reset mid-note: item 3, note 2 (half 285) is high at edge 2300
        // with a second cue queued; reset must silence and empty everything.
        $display("[TB] reset mid-note sequence");
        cur         = -1;
        vend_event  = 1'b1;
        item_select = 2'd3;
        tick_to(0);
        tick_to(9);
        vend_event  = 1'b1;
        item_select = 2'd0;
        tick_to(10);
        tick_to(2300);
        checkOutput("midreset pre audio", audio_out, 1'b1);
        checkOutput("midreset pre busy", busy, 1'b1);
        rst = 1'b1;
        tick_to(2301);
        rst = 1'b0;
        checkOutput("midreset audio", audio_out, 1'b0);
        checkOutput("midreset busy", busy, 1'b0);
        checkOutput("midreset full", queue_full, 1'b0);
        checkOutput("midreset dropped", dropped, 1'b0);
        bad = 0;
        while (cur < 9300) begin
            tick_to(cur + 1);
            if (audio_out !== 1'b0 || busy !== 1'b0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL midreset quiet: %0d active cycles, expected 0", bad);
        end

`ifdef ERROR_PREEMPT_EN
        // Error during note 1 of an item-0 cue with two cues queued.
        $display("[TB] preempt sequence");
        cur         = -1;
        vend_event  = 1'b1;
        item_select = 2'd0;
        tick_to(0);
        vend_event  = 1'b1;
        item_select = 2'd1;
        tick_to(1);
        vend_event  = 1'b1;
        item_select = 2'd2;
        tick_to(2);
        tick_to(699);
        checkOutput("preempt pre audio", audio_out, 1'b1);
        error_event = 1'b1;
        tick_to(700);
        checkOutput("preempt audio", audio_out, 1'b0);
        checkOutput("preempt busy", busy, 1'b1);
        checkOutput("preempt full", queue_full, 1'b0);
        checkOutput("preempt dropped", dropped, 1'b0);
        monitor_to(6699, bad);
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL preempt quiet: %0d cycles with audio/dropped, expected 0", bad);
        end
        checkOutput("preempt busy end", busy, 1'b1);
        tick_to(6700);
        checkOutput("preempt done", busy, 1'b0);
        monitor_to(7400, bad);
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL preempt flushed: %0d cycles with audio/dropped, expected 0", bad);
        end
        checkOutput("preempt idle", busy, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
